bank_encoder: RTL
=================

// Module: bank_encoder
// PURPOSE
//   Reverse direction of the bank-select decoder: turns an N-bit one-hot/multi-hot
//   bank-select mask back into a stream of binary bank addresses.
//   Accepts one mask per input handshake. Emits one address per output handshake,
//   in ascending index order (lowest set bit first).
//   Sits between the MVU bank-select logic and sequential bank-access control.
// PARAMETERS
//   n  32  number of banks / mask width (>=2)
//   a  $clog2(n)  localparam, address width
// PORTS
//   clk      in   1    clock, rising edge
//   rst      in   1    synchronous reset, active high
//   i_mask   in   n    bank-select mask (bit i set => emit address i)
//   i_valid  in   1    i_mask valid
//   i_ready  out  1    encoder can accept a mask
//   o_addr   out  a    current bank address
//   o_valid  out  1    o_addr valid
//   o_ready  in   1    downstream accepts o_addr
//   o_last   out  1    o_addr is the final address for the current mask
//   o_done   out  1    one-cycle pulse: the current mask is fully emitted
// BEHAVIOUR
//   Clock and reset: one clock; reset is synchronous and active-high.
//   Reset state:
//     - State IDLE; pend = 0; o_valid = 0; o_last = 0; o_done = 0; o_addr = 0.
//     - i_ready = 1 from the first edge after rst falls.
//     - rst wins over every other event in the same cycle.
//   State IDLE:
//     - i_ready = 1; o_valid = 0.
//     - i_valid & i_ready with i_mask != 0: pend <= i_mask; go to BUSY.
//     - i_valid & i_ready with i_mask == 0: mask consumed, stay IDLE,
//       o_done pulses on the next cycle, no address emitted.
//   State BUSY:
//     - i_ready = 0; o_valid = 1 (combinational from state).
//     - o_addr = index of lowest set bit of pend (combinational priority encode).
//     - o_last = (pend has exactly one bit set).
//     - o_valid & o_ready: clear that bit in pend.
//       If it was the last bit: go to IDLE, o_done = 1 for one cycle.
//     - o_ready low: o_addr, o_valid, o_last hold stable. No bit is dropped.
//   Latency: first o_valid is 1 cycle after input accept. One address per cycle
//     under o_ready = 1. A k-bit mask needs k+1 cycles accept-to-IDLE;
//     the next mask can be accepted on the cycle IDLE is re-entered.
//   Input changes: i_mask changes while BUSY are ignored; only the captured pend
//     is used.
//   Reset mid-operation: pend is discarded; no further o_valid; no o_done pulse.
//   Bit n-1 set: emits address n-1 (all-ones for n a power of 2); no wrap.
//   Non-power-of-2 n: addresses >= n are never produced.
// TESTING
//   1 (n=32) Ascending emit: mask 32'h8000_8011, o_ready=1.
//     -> o_addr 0,4,15,31 on 4 consecutive cycles; o_last only with 31;
//        o_done 1 cycle later; i_ready=1 after.
//   2 Backpressure: mask 32'h0000_0006, o_ready low 3 cycles, then high.
//     -> o_addr=1 held stable 3 cycles, then 1, 2; no loss, no duplication.
//   3 Zero mask: i_mask=0 accepted.
//     -> o_valid never rises; o_done pulses next cycle; i_ready stays 1.
//   4 Single bit: mask 32'h8000_0000.
//     -> single beat o_addr=31 with o_last=1.
//     Back-to-back with mask 32'h1 -> o_addr=0 accepted right after.
//   5 Reset mid-op: mask 32'hFFFF_FFFF, rst after 5 beats (addr 0..4 emitted).
//     -> next cycle o_valid=0, o_done=0, i_ready=1; a new mask 32'h4 yields only addr 2.
//   6 Ignore-while-busy: toggle i_valid/i_mask during BUSY.
//     -> i_ready=0 throughout; output stream matches the originally captured mask only.

Source files
------------

// File: rtl/bank_encoder.sv
// Mask-to-address serializer: captures a bank-select mask and emits the index
// of every set bit, lowest first, one per output handshake.
module bank_encoder #(
    parameter  int n = 32,
    localparam int a = $clog2(n)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] i_mask,
    input  logic         i_valid,
    output logic         i_ready,
    output logic [a-1:0] o_addr,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         o_last,
    output logic         o_done
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state, state_nxt;
    logic [n-1:0] pend, pend_nxt, pend_rest;
    logic [a-1:0] addr_enc;
    logic         last, done_nxt;

    // Clearing the lowest set bit is the same as consuming the encoded address.
    assign pend_rest = pend & (pend - n'(1));
    assign last      = (pend != '0) && (pend_rest == '0);

    always_comb begin
        addr_enc = '0;
        for (int i = n - 1; i >= 0; i--)
            if (pend[i]) addr_enc = a'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= '0;
            o_done <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend   <= pend_nxt;
            o_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    if (i_mask != '0) begin
                        pend_nxt  = i_mask;
                        state_nxt = BUSY;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (o_ready) begin
                    pend_nxt = pend_rest;
                    if (last) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pend is zero whenever IDLE, so o_addr rests at 0 outside BUSY.
    always_comb begin
        i_ready = (state == IDLE);
        o_valid = (state == BUSY);
        o_addr  = addr_enc;
        o_last  = (state == BUSY) && last;
    end

endmodule
